de_pipe_reg: RTL and testbench

//  ID->EX pipeline register; direct consumer of the data-hazard stall signal.

---
 rtl/de_pipe_reg_pkg.sv | 45 ++++
 rtl/de_pipe_reg_if.sv | 32 +++
 rtl/de_pipe_reg_sat_counter.sv | 25 ++
 rtl/de_pipe_reg.sv | 89 ++++++++
 tb/tb_de_pipe_reg.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/de_pipe_reg_pkg.sv
// de_pipe_reg_pkg: result classes, exception codes, NOP and the D/E bundle shared by the pipeline registers
package de_pipe_reg_pkg;

   typedef enum logic [1:0] {
      RES_NW  = 2'b00,
      RES_ALU = 2'b01,
      RES_DM  = 2'b10,
      RES_PC  = 2'b11
   } res_t;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic {
      RUN_IDLE,
      RUN_ACTIVE
   } run_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] ext;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [4:0]  a3;
      res_t        res;
      logic [4:0]  exc;
      logic        bd;
   } de_bus_t;

   // A bubble writes no register (a3 = 0, res = NW) so it can never raise a hazard,
   // but it keeps pc/bd so an interrupt taken on it still reports the right EPC.
   function automatic de_bus_t bubble(input logic [31:0] pc, input logic bd);
      bubble = '{pc: pc, instr: NOP, rs_val: '0, rt_val: '0, ext: '0,
                 a1: '0, a2: '0, a3: '0, res: RES_NW, exc: EXC_NONE, bd: bd};
   endfunction

endpackage

// File: rtl/de_pipe_reg_if.sv
// de_pipe_reg_if: D-stage inputs, E-stage outputs and stall statistics of the ID->EX register
interface de_pipe_reg_if #(parameter int CNT_W = 16);

   logic              Stall_Data;
   logic              flush;
   logic [31:0]       pc_d, instr_d, rs_val_d, rt_val_d, ext_d;
   logic [4:0]        a1_d, a2_d, a3_d, exc_d;
   logic [1:0]        res_d;
   logic              bd_d;
   logic [31:0]       pc_e, instr_e, rs_val_e, rt_val_e, ext_e;
   logic [4:0]        a1_e, a2_e, a3_e, exc_e;
   logic [1:0]        res_e;
   logic              bd_e;
   logic              valid_e;
   logic [CNT_W-1:0]  stall_cnt;
   logic              stall_timeout;

   modport master (
      output Stall_Data, flush, pc_d, instr_d, rs_val_d, rt_val_d, ext_d,
             a1_d, a2_d, a3_d, exc_d, res_d, bd_d,
      input  pc_e, instr_e, rs_val_e, rt_val_e, ext_e, a1_e, a2_e, a3_e,
             exc_e, res_e, bd_e, valid_e, stall_cnt, stall_timeout
   );

   modport slave (
      input  Stall_Data, flush, pc_d, instr_d, rs_val_d, rt_val_d, ext_d,
             a1_d, a2_d, a3_d, exc_d, res_d, bd_d,
      output pc_e, instr_e, rs_val_e, rt_val_e, ext_e, a1_e, a2_e, a3_e,
             exc_e, res_e, bd_e, valid_e, stall_cnt, stall_timeout
   );

endinterface

// File: rtl/de_pipe_reg_sat_counter.sv
// sat_counter: counter that clears on clr_i, increments on inc_i and holds at MAX
module sat_counter #(
   parameter int         W   = 4,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_d, cnt_q;

   // Clear wins over increment; the count never passes MAX.
   always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;

   // Count register.
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;

   assign cnt_o = cnt_q;

endmodule

// File: rtl/de_pipe_reg.sv
// de_pipe_reg: ID->EX pipeline register with stall bubbles, flush, stall counting and a stall watchdog
module de_pipe_reg
   import de_pipe_reg_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = 32'h0000_3000,
   parameter int          CNT_W     = 16,
   parameter int          STALL_MAX = 8
) (
   input  logic            clk,
   input  logic            reset,
   de_pipe_reg_if.slave    bus
);

   localparam int RUN_W = $clog2(STALL_MAX + 1);

   de_bus_t          d_bus, e_d, e_q;
   logic             valid_d, valid_q;
   logic             stall_ev, run_last, timeout_q;
   run_state_t       state_q;
   logic [RUN_W-1:0] run_cnt;
   logic [CNT_W-1:0] stall_cnt;

   assign d_bus = '{pc: bus.pc_d, instr: bus.instr_d, rs_val: bus.rs_val_d,
                    rt_val: bus.rt_val_d, ext: bus.ext_d, a1: bus.a1_d, a2: bus.a2_d,
                    a3: bus.a3_d, res: res_t'(bus.res_d), exc: bus.exc_d, bd: bus.bd_d};

   // A flushed stall is not a stall: it is neither counted nor extends a run.
   assign stall_ev = bus.Stall_Data & ~bus.flush;

   // Next E contents: flush > stall bubble > load.
   always_comb begin
      e_d      = bus.flush ? bubble(32'h0, 1'b0) : bus.Stall_Data ? bubble(bus.pc_d, bus.bd_d) : d_bus;
      valid_d  = ~(bus.flush | bus.Stall_Data);
      run_last = (state_q == RUN_ACTIVE) ? (run_cnt == RUN_W'(STALL_MAX - 1)) : (STALL_MAX == 1);
   end

   // E-stage register.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         e_q     <= bubble(PC_RESET, 1'b0);
         valid_q <= 1'b0;
      end else begin
         e_q     <= e_d;
         valid_q <= valid_d;
      end

   // Run FSM: tracks whether a stall run is in progress and latches the watchdog
   // on the edge that completes STALL_MAX consecutive stalls.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q   <= RUN_IDLE;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= stall_ev ? RUN_ACTIVE : RUN_IDLE;
         timeout_q <= timeout_q | (stall_ev & run_last);
      end

   sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (stall_ev),
      .clr_i (1'b0),
      .cnt_o (stall_cnt)
   );

   sat_counter #(.W(RUN_W), .MAX(RUN_W'(STALL_MAX))) u_run_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (stall_ev),
      .clr_i (~stall_ev),
      .cnt_o (run_cnt)
   );

   assign bus.pc_e          = e_q.pc;
   assign bus.instr_e       = e_q.instr;
   assign bus.rs_val_e      = e_q.rs_val;
   assign bus.rt_val_e      = e_q.rt_val;
   assign bus.ext_e         = e_q.ext;
   assign bus.a1_e          = e_q.a1;
   assign bus.a2_e          = e_q.a2;
   assign bus.a3_e          = e_q.a3;
   assign bus.res_e         = e_q.res;
   assign bus.exc_e         = e_q.exc;
   assign bus.bd_e          = e_q.bd;
   assign bus.valid_e       = valid_q;
   assign bus.stall_cnt     = stall_cnt;
   assign bus.stall_timeout = timeout_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// tb_de_pipe_reg: randomized and directed checks of de_pipe_reg against a behavioural model
module tb_de_pipe_reg;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic chk_en = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   logic        stall, flush;
   logic [31:0] pc_d, instr_d, rs_d, rt_d, ext_d;
   logic [4:0]  a1_d, a2_d, a3_d, exc_d;
   logic [1:0]  res_d;
   logic        bd_d;

   de_pipe_reg_if #(.CNT_W(16)) b16 ();
   de_pipe_reg_if #(.CNT_W(4))  b4 ();

   de_pipe_reg #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));
   de_pipe_reg #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(b4));

   assign b16.Stall_Data = stall;   assign b4.Stall_Data = stall;
   assign b16.flush      = flush;   assign b4.flush      = flush;
   assign b16.pc_d       = pc_d;    assign b4.pc_d       = pc_d;
   assign b16.instr_d    = instr_d; assign b4.instr_d    = instr_d;
   assign b16.rs_val_d   = rs_d;    assign b4.rs_val_d   = rs_d;
   assign b16.rt_val_d   = rt_d;    assign b4.rt_val_d   = rt_d;
   assign b16.ext_d      = ext_d;   assign b4.ext_d      = ext_d;
   assign b16.a1_d       = a1_d;    assign b4.a1_d       = a1_d;
   assign b16.a2_d       = a2_d;    assign b4.a2_d       = a2_d;
   assign b16.a3_d       = a3_d;    assign b4.a3_d       = a3_d;
   assign b16.exc_d      = exc_d;   assign b4.exc_d      = exc_d;
   assign b16.res_d      = res_d;   assign b4.res_d      = res_d;
   assign b16.bd_d       = bd_d;    assign b4.bd_d       = bd_d;

   always #5 clk = ~clk;

   // Behavioural model: what E must hold after each edge, plus stall totals and run length.
   logic [31:0] m_pc, m_instr, m_rs, m_rt, m_ext;
   logic [4:0]  m_a1, m_a2, m_a3, m_exc;
   logic [1:0]  m_res;
   logic        m_bd, m_valid, m_to;
   int          m_cnt, m_run;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         {m_instr, m_rs, m_rt, m_ext, m_a1, m_a2, m_a3, m_exc, m_res, m_bd, m_valid, m_to} = '0;
         m_pc = 32'h3000; m_cnt = 0; m_run = 0;
      end else begin
         if (flush || stall) begin
            {m_instr, m_rs, m_rt, m_ext, m_a1, m_a2, m_a3, m_exc, m_res, m_valid} = '0;
            m_pc = flush ? 32'h0 : pc_d;
            m_bd = flush ? 1'b0 : bd_d;
         end else begin
            m_pc = pc_d; m_instr = instr_d; m_rs = rs_d; m_rt = rt_d; m_ext = ext_d;
            m_a1 = a1_d; m_a2 = a2_d; m_a3 = a3_d; m_exc = exc_d; m_res = res_d;
            m_bd = bd_d; m_valid = 1'b1;
         end
         if (stall && !flush) begin
            m_cnt++;
            m_run++;
            if (m_run >= 8) m_to = 1'b1;
         end else m_run = 0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every cycle out of reset, both DUTs must match the model.
   always @(negedge clk) begin
      if (reset && chk_en) begin
         chk("pc_e",     64'(b16.pc_e),     64'(m_pc));
         chk("instr_e",  64'(b16.instr_e),  64'(m_instr));
         chk("rs_val_e", 64'(b16.rs_val_e), 64'(m_rs));
         chk("rt_val_e", 64'(b16.rt_val_e), 64'(m_rt));
         chk("ext_e",    64'(b16.ext_e),    64'(m_ext));
         chk("a1_e",     64'(b16.a1_e),     64'(m_a1));
         chk("a2_e",     64'(b16.a2_e),     64'(m_a2));
         chk("a3_e",     64'(b16.a3_e),     64'(m_a3));
         chk("exc_e",    64'(b16.exc_e),    64'(m_exc));
         chk("res_e",    64'(b16.res_e),    64'(m_res));
         chk("bd_e",     64'(b16.bd_e),     64'(m_bd));
         chk("valid_e",  64'(b16.valid_e),  64'(m_valid));
         chk("stall_cnt16",   64'(b16.stall_cnt), 64'(m_cnt > 65535 ? 65535 : m_cnt));
         chk("stall_cnt4",    64'(b4.stall_cnt),  64'(m_cnt > 15 ? 15 : m_cnt));
         chk("timeout16",     64'(b16.stall_timeout), 64'(m_to));
         chk("timeout4",      64'(b4.stall_timeout),  64'(m_to));
         chk("pc_e4",         64'(b4.pc_e),  64'(m_pc));
         chk("valid_e4",      64'(b4.valid_e), 64'(m_valid));
      end
   end

   task automatic rand_d();
      pc_d = $urandom; instr_d = $urandom; rs_d = $urandom; rt_d = $urandom; ext_d = $urandom;
      a1_d = 5'($urandom); a2_d = 5'($urandom); a3_d = 5'($urandom); exc_d = 5'($urandom);
      res_d = 2'($urandom); bd_d = 1'($urandom);
   endtask

   task automatic cyc(input logic s, input logic f);
      rand_d();
      stall = s; flush = f;
      @(negedge clk);
   endtask

   task automatic rand_phase(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(15) == 0) begin
            int len = $urandom_range(12, 5);
            for (int j = 0; j < len; j++) cyc(1'b1, 1'b0);
         end else cyc(1'($urandom_range(99) < 35), 1'($urandom_range(99) < 10));
      end
   endtask

   initial begin
      stall = 1'b0; flush = 1'b0; rand_d();
      repeat (3) @(negedge clk);
      reset = 1'b1; chk_en = 1'b1;

      rand_d(); stall = 1'b0; flush = 1'b0;
      pc_d = 32'h3004; a3_d = 5'd8; res_d = 2'b01;
      @(negedge clk);
      chk("t1 pc_e", 64'(b16.pc_e), 64'h3004);
      chk("t1 a3_e", 64'(b16.a3_e), 64'd8);
      chk("t1 res_e", 64'(b16.res_e), 64'd1);
      chk("t1 valid_e", 64'(b16.valid_e), 64'd1);

      rand_d(); instr_d = 32'h2409_0001; stall = 1'b1;
      pc_d = 32'h3010; bd_d = 1'b1; a3_d = 5'd9; res_d = 2'b10;
      @(negedge clk);
      chk("t2 instr_e", 64'(b16.instr_e), 64'h0);
      chk("t2 a3_e", 64'(b16.a3_e), 64'h0);
      chk("t2 res_e", 64'(b16.res_e), 64'h0);
      chk("t2 valid_e", 64'(b16.valid_e), 64'h0);
      chk("t2 pc_e", 64'(b16.pc_e), 64'h3010);
      chk("t2 bd_e", 64'(b16.bd_e), 64'h1);
      chk("t2 stall_cnt", 64'(b16.stall_cnt), 64'd1);

      rand_d(); pc_d = 32'h3014; bd_d = 1'b1; stall = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("t3 pc_e", 64'(b16.pc_e), 64'h0);
      chk("t3 bd_e", 64'(b16.bd_e), 64'h0);
      chk("t3 valid_e", 64'(b16.valid_e), 64'h0);
      chk("t3 stall_cnt", 64'(b16.stall_cnt), 64'd1);

      repeat (7) cyc(1'b1, 1'b0);
      chk("t3 run cleared", 64'(b16.stall_timeout), 64'd0);
      cyc(1'b0, 1'b0);
      repeat (7) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("t4 7-1-7 timeout", 64'(b16.stall_timeout), 64'd0);
      chk("t5 stall_cnt4 at 15", 64'(b4.stall_cnt), 64'd15);
      repeat (7) cyc(1'b1, 1'b0);
      chk("t4 7th edge", 64'(b16.stall_timeout), 64'd0);
      cyc(1'b1, 1'b0);
      chk("t4 8th edge", 64'(b16.stall_timeout), 64'd1);
      cyc(1'b0, 1'b0);
      chk("t4 sticky", 64'(b16.stall_timeout), 64'd1);
      chk("t5 stall_cnt16", 64'(b16.stall_cnt), 64'd23);
      chk("t5 stall_cnt4 held", 64'(b4.stall_cnt), 64'd15);

      rand_phase(300);

      rand_d(); stall = 1'b1; flush = 1'b0;
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk("t6 pc_e", 64'(b16.pc_e), 64'h3000);
      chk("t6 res_e", 64'(b16.res_e), 64'h0);
      chk("t6 valid_e", 64'(b16.valid_e), 64'h0);
      chk("t6 instr_e", 64'(b16.instr_e), 64'h0);
      chk("t6 bd_e", 64'(b16.bd_e), 64'h0);
      chk("t6 stall_cnt", 64'(b16.stall_cnt), 64'h0);
      chk("t6 timeout", 64'(b16.stall_timeout), 64'h0);
      @(negedge clk);
      reset = 1'b1;

      rand_phase(300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
